// File: rtl/branch_ctrl.sv
// Branch/PC controller: latches ALU compare flags, resolves branches, owns the PC, flushes after taken branches.
// Optional macro BRANCH_CTRL_FLAG_FWD_EN forwards same-cycle CMP flags into the branch condition.
//
// state   | meaning
// S_IDLE  | waiting for start, pc holds
// S_RUN   | fetching, resolving branches/halt
// S_FLUSH | squashing wrong-path instructions after a taken branch
// S_HALT  | stopped, waiting for start
module branch_ctrl #(
  parameter int PC_W      = 10,
  parameter int OFFS_W    = 8,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [PC_W-1:0]   start_addr_i,
  input  logic              stall_i,
  input  logic              cmp_valid_i,
  input  logic              ge_flg_i,
  input  logic              ne_flg_i,
  input  logic              br_valid_i,
  input  logic [1:0]        br_cond_i,
  input  logic [OFFS_W-1:0] br_offset_i,
  input  logic              halt_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              flag_ge_o,
  output logic              flag_ne_o
);

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flush_q;
  logic              busy_q;
  logic              done_q;
  logic              flag_ge_q;
  logic              flag_ne_q;

  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   br_tgt;
  logic              cond_ge;
  logic              cond_ne;
  logic              br_taken;

  if (PC_W > OFFS_W) begin : g_sext
    assign off_ext = {{(PC_W-OFFS_W){br_offset_i[OFFS_W-1]}}, br_offset_i};
  end else begin : g_trunc
    assign off_ext = br_offset_i[PC_W-1:0];
  end

  assign pc_inc = pc_q + 1'b1;
  assign br_tgt = pc_q + off_ext;

`ifdef BRANCH_CTRL_FLAG_FWD_EN
  assign cond_ge = cmp_valid_i ? ge_flg_i : flag_ge_q;
  assign cond_ne = cmp_valid_i ? ne_flg_i : flag_ne_q;
`else
  // Same-cycle CMP is not visible here; decode keeps CMP and branch apart.
  assign cond_ge = flag_ge_q;
  assign cond_ne = flag_ne_q;
`endif

  always_comb begin
    br_taken = 1'b0;
    case (br_cond_i)
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = cond_ge;
      2'b10:   br_taken = cond_ne;
      default: br_taken = ~cond_ne;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      flag_ge_q <= 1'b0;
      flag_ne_q <= 1'b0;
    end else if (!stall_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            pc_q    <= start_addr_i;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (cmp_valid_i) begin
            flag_ge_q <= ge_flg_i;
            flag_ne_q <= ne_flg_i;
          end
          if (halt_i) begin
            state_q <= S_HALT;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (br_valid_i && br_taken) begin
            state_q <= S_FLUSH;
            pc_q    <= br_tgt;
            cnt_q   <= CNT_INIT;
            flush_q <= 1'b1;
          end else begin
            pc_q <= pc_inc;
          end
        end
        S_FLUSH: begin
          pc_q <= pc_inc;
          if (cnt_q == '0) begin
            state_q <= S_RUN;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HALT: begin
          if (start_i) begin
            state_q <= S_RUN;
            pc_q    <= start_addr_i;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc_o      = pc_q;
  assign flush_o   = flush_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign flag_ge_o = flag_ge_q;
  assign flag_ne_o = flag_ne_q;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Consumes the ALU compare status (geFlg/neFlg) and branch requests; owns the program counter.
- Latches flags on CMP, resolves conditional branches, computes next PC and issues a pipeline flush after taken branches.
- Sits between the ALU/decode stage and instruction fetch.
- Handles start/halt sequencing for the processor.

Parameters:
PC_W, 10, program counter width (instruction ROM depth 2^PC_W)
OFFS_W, 8, signed branch offset width (matches byteW)
FLUSH_CYC, 2, flush cycles after a taken branch (>=1)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
start  in  1  begin execution at start_addr
start_addr  in  PC_W  initial PC
stall  in  1  hazard hold; freezes PC, state and counters
cmp_valid  in  1  ALU executed CMP this cycle
ge_flg  in  1  ALU greater-or-equal flag
ne_flg  in  1  ALU not-equal flag
br_valid  in  1  branch instruction at pc
br_cond  in  2  00 always, 01 BGE (ge), 10 BNE (ne), 11 BEQ (!ne)
br_offset  in  OFFS_W  signed offset, two's complement
halt  in  1  halt instruction at pc
pc  out  PC_W  address of instruction in flight
flush  out  1  squash younger pipeline stages
busy  out  1  high in RUN/FLUSH
done  out  1  high in HALT
flag_ge  out  1  latched ge flag
flag_ne  out  1  latched ne flag

Behaviour:
- Reset (reset=1 at posedge): state IDLE; pc=0, flush=0, busy=0, done=0, flag_ge=0, flag_ne=0, flush counter=0. Reset wins over every other input, mid-operation included.
- States:
  - IDLE: pc holds.
  - start → RUN, pc<=start_addr, busy=1.
  - RUN, stall=0, evaluated in this priority order:
    - halt → HALT, pc holds, done=1, busy=0.
    - else br_valid with condition true → FLUSH, pc <= pc + sext(br_offset) mod 2^PC_W, counter<=FLUSH_CYC-1, flush=1.
    - else pc <= pc+1 (wraps 2^PC_W-1 → 0).
  - RUN: cmp_valid latches flag_ge<=ge_flg, flag_ne<=ne_flg the same edge. This applies even when halt or a branch is present.
  - FLUSH: flush=1; pc <= pc+1 each non-stalled cycle. Counter decrements each non-stalled cycle; counter==0 → RUN and flush deasserts the next cycle. Total flush-high cycles = FLUSH_CYC absent stalls.
  - FLUSH: br_valid, cmp_valid and halt are ignored (wrong-path instructions).
  - HALT: pc, flags hold; start → RUN with pc<=start_addr, done<=0, flags preserved.
- start is ignored in RUN/FLUSH.
- stall=1: pc, state, counter and flags hold. flush keeps its current value. All inputs are ignored that cycle.
- Condition evaluation uses latched flag_ge/flag_ne. br_cond=00 is always taken.
- Offset arithmetic: sign-extend br_offset to PC_W, add, truncate. Offset 0 = branch-to-self (legal, still flushes).
- All outputs are registered; a decision made at edge N is visible after edge N.

Optional Feature:
- Macro: BRANCH_CTRL_FLAG_FWD_EN.
- Defined: when cmp_valid and br_valid are both high in the same RUN cycle, the condition uses incoming ge_flg/ne_flg (forwarded). Flags are still latched.
- Undefined: the condition always uses the latched flags, so a same-cycle CMP+branch sees the previous flags. Decode must separate CMP and branch by ≥1 instruction.

Test Plan:
- Reset then start with start_addr=0x010 → pc=0x010, busy=1; 3 idle cycles → pc=0x013; flush=0 throughout.
- At pc=0x020: cmp_valid with ge=1,ne=1; next cycle BGE offset=0xFC (−4) → pc=0x01D, flush high exactly 2 cycles, then pc=0x01E, 0x01F increments.
- Flags ge=0,ne=0 latched; BNE offset=+5 at pc=0x030 → not taken, pc=0x031, flush=0. BEQ offset=+5 at 0x031 → pc=0x036.
- pc=0x3FF with no branch → pc wraps to 0x000. Branch always at 0x3FE offset=+3 → pc=0x001.
- During FLUSH, stall held 3 cycles → pc, counter and flush frozen; br_valid/halt pulsed in FLUSH → ignored. Reset asserted mid-FLUSH → all outputs 0, state IDLE.
- halt and br_valid same cycle at pc=0x040 → HALT, pc=0x040, done=1. Same-cycle cmp_valid(ge=1)+BGE after flags ge=0: taken only with BRANCH_CTRL_FLAG_FWD_EN defined.
